// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback and decodes datapath controls.
// Outputs are combinational from state and instruction fields; FETCH, MEMREAD and MEMWRITE stall on mem_ready.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic [4:0]  ALUControl,
    output logic [3:0]  state,
    output logic        retire,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SLL   = 5'b00101;
    localparam logic [4:0] ALU_SRL   = 5'b00110;
    localparam logic [4:0] ALU_SRA   = 5'b00111;
    localparam logic [4:0] ALU_SLTU  = 5'b01000;
    localparam logic [4:0] ALU_SLT   = 5'b01001;
    localparam logic [4:0] ALU_PASSB = 5'b10000;

    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;

    logic        pc_w, ir_w, reg_w, mem_w, mem_r, ret;
    logic [4:0]  r_alu, i_alu;
    logic        r_ok, i_ok;
    logic [2:0]  dec_imm;

    // ALU op decode for register and immediate arithmetic; *_ok low flags encodings with no defined op.
    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case ({funct7, funct3})
            {7'h00, 3'b000}: r_alu = ALU_ADD;
            {7'h00, 3'b001}: r_alu = ALU_SLL;
            {7'h00, 3'b010}: r_alu = ALU_SLT;
            {7'h00, 3'b011}: r_alu = ALU_SLTU;
            {7'h00, 3'b100}: r_alu = ALU_XOR;
            {7'h00, 3'b101}: r_alu = ALU_SRL;
            {7'h00, 3'b110}: r_alu = ALU_OR;
            {7'h00, 3'b111}: r_alu = ALU_AND;
            {7'h20, 3'b000}: r_alu = ALU_SUB;
            {7'h20, 3'b101}: r_alu = ALU_SRA;
            default:         r_ok  = 1'b0;
        endcase

        i_ok  = 1'b1;
        i_alu = ALU_ADD;
        case (funct3)
            3'b000: i_alu = ALU_ADD;
            3'b010: i_alu = ALU_SLT;
            3'b011: i_alu = ALU_SLTU;
            3'b100: i_alu = ALU_XOR;
            3'b110: i_alu = ALU_OR;
            3'b111: i_alu = ALU_AND;
            3'b001: begin
                i_alu = ALU_SLL;
                i_ok  = (funct7 == 7'h00);
            end
            default: begin
                if (funct7 == 7'h00) begin
                    i_alu = ALU_SRL;
                end else if (funct7 == 7'h20) begin
                    i_alu = ALU_SRA;
                end else begin
                    i_ok = 1'b0;
                end
            end
        endcase

        case (opcode)
            OP_STORE:  dec_imm = 3'b001;
            OP_BRANCH: dec_imm = 3'b010;
            OP_JAL:    dec_imm = 3'b011;
            OP_LUI:    dec_imm = 3'b100;
            default:   dec_imm = 3'b000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        mem_r      = 1'b0;
        ret        = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_r     = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_w      = mem_ready;
                pc_w      = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = dec_imm;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OP_LOAD) ? 3'b000 : 3'b001;
                state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_r  = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
                ret       = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
                if (mem_ready) begin
                    ret     = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = r_alu;
                state_d    = r_ok ? S_ALUWB : S_TRAP;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = i_alu;
                state_d    = i_ok ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                ret     = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                ImmSrc     = 3'b010;
                case (funct3)
                    3'b000: begin
                        pc_w    = Zero;
                        ret     = 1'b1;
                        state_d = S_FETCH;
                    end
                    3'b001: begin
                        pc_w    = ~Zero;
                        ret     = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pc_w    = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_w      = 1'b1;
                state_d   = S_JAL;
            end
            S_LUI: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 3'b100;
                ALUControl = ALU_PASSB;
                state_d    = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Enables and retire are masked while reset is high so nothing commits in the reset cycle.
    assign PCWrite  = pc_w  & ~reset;
    assign IRWrite  = ir_w  & ~reset;
    assign RegWrite = reg_w & ~reset;
    assign MemWrite = mem_w & ~reset;
    assign MemRead  = mem_r & ~reset;
    assign retire   = ret   & ~reset;

    assign illegal_d = illegal_q | (state_d == S_TRAP);
    assign instret_d = instret_q + {31'd0, retire};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction streams checked against a path model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        Zero, mem_ready;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]  ImmSrc;
    logic [4:0]  ALUControl;
    logic [3:0]  state;
    logic        retire, illegal;
    logic [31:0] instret;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_instret;

    // ALU code for each funct3 when funct7 is zero: ADD SLL SLT SLTU XOR SRL OR AND
    localparam int ALU_BY_F3 [8] = '{0, 5, 9, 8, 4, 6, 3, 2};

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .state(state), .retire(retire), .illegal(illegal),
        .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int alu_code(input bit imm, input logic [6:0] f7, input logic [2:0] f3);
        if (imm) begin
            if (f3 == 3'd1) return (f7 == 7'h00) ? 5 : -1;
            if (f3 == 3'd5) return (f7 == 7'h00) ? 6 : ((f7 == 7'h20) ? 7 : -1);
            return ALU_BY_F3[f3];
        end
        if (f7 == 7'h00) return ALU_BY_F3[f3];
        if (f7 == 7'h20 && f3 == 3'd0) return 1;
        if (f7 == 7'h20 && f3 == 3'd5) return 7;
        return -1;
    endfunction

    function automatic bit is_known(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    endfunction

    task automatic set_instr(input logic [31:0] ins);
        opcode = ins[6:0];
        funct3 = ins[14:12];
        funct7 = ins[31:25];
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
        set_instr(32'h0);
        @(negedge clk);
        checks++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, MemRead, retire} !== 6'b0) begin
            errors++;
            $display("FAIL reset_enables: got %b expected 000000",
                     {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, retire});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({state, illegal, instret} !== {4'd0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: got state=%0d illegal=%b instret=%h expected 0/0/0",
                     state, illegal, instret);
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        exp_instret = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({state, MemRead, IRWrite, PCWrite, ALUSrcB, ResultSrc} !== {4'd0, 3'b100, 2'b10, 2'b10}) begin
                errors++;
                $display("FAIL fetch_hold: got %h expected %h",
                         {state, MemRead, IRWrite, PCWrite, ALUSrcB, ResultSrc},
                         {4'd0, 3'b100, 2'b10, 2'b10});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add;
        int seq [4] = '{0, 1, 6, 8};
        set_instr(32'h002081B3);
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; Zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (state !== 4'(seq[i]) || RegWrite !== (seq[i] == 8)) begin
                errors++;
                $display("FAIL add_step%0d: got state=%0d RegWrite=%b expected state=%0d RegWrite=%b",
                         i, state, RegWrite, seq[i], seq[i] == 8);
            end
            if (seq[i] == 6) begin
                checks++;
                if (ALUControl !== 5'b00000) begin
                    errors++;
                    $display("FAIL add_aluctl: got %b expected 00000", ALUControl);
                end
            end
            @(posedge clk); #1;
        end
        exp_instret++;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || instret !== exp_instret) begin
            errors++;
            $display("FAIL add_done: got state=%0d instret=%h expected 0/%h", state, instret, exp_instret);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw_stall;
        int  seq [8] = '{0, 1, 2, 3, 3, 3, 3, 4};
        bit  mrs [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        set_instr({7'd0, 5'd0, 5'd1, 3'b010, 5'd3, 7'b0000011});
        for (int i = 0; i < 8; i++) begin
            mem_ready = mrs[i];
            @(negedge clk);
            checks++;
            if (state !== 4'(seq[i]) || RegWrite !== (seq[i] == 4)) begin
                errors++;
                $display("FAIL lw_step%0d: got state=%0d RegWrite=%b expected state=%0d RegWrite=%b",
                         i, state, RegWrite, seq[i], seq[i] == 4);
            end
            if (seq[i] == 2) begin
                checks++;
                if ({ALUSrcA, ALUSrcB, ImmSrc} !== {2'b10, 2'b01, 3'b000}) begin
                    errors++;
                    $display("FAIL lw_memadr: got %b expected 1001000", {ALUSrcA, ALUSrcB, ImmSrc});
                end
            end
            if (seq[i] == 3) begin
                checks++;
                if ({MemRead, AdrSrc} !== 2'b11) begin
                    errors++;
                    $display("FAIL lw_memread: got %b expected 11", {MemRead, AdrSrc});
                end
            end
            if (seq[i] == 4) begin
                checks++;
                if ({ResultSrc, retire} !== 3'b011) begin
                    errors++;
                    $display("FAIL lw_memwb: got %b expected 011", {ResultSrc, retire});
                end
            end
            @(posedge clk); #1;
        end
        exp_instret++;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || instret !== exp_instret) begin
            errors++;
            $display("FAIL lw_done: got state=%0d instret=%h expected 0/%h", state, instret, exp_instret);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_branch;
        int seq [3] = '{0, 1, 9};
        for (int k = 0; k < 2; k++) begin
            set_instr({7'd0, 5'd2, 5'd1, 3'(k), 5'd8, 7'b1100011});
            Zero = 1'b1;
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b1;
                @(negedge clk);
                checks++;
                if (state !== 4'(seq[i])) begin
                    errors++;
                    $display("FAIL br%0d_step%0d: got state=%0d expected %0d", k, i, state, seq[i]);
                end
                if (seq[i] == 9) begin
                    checks++;
                    if ({PCWrite, retire, ALUControl, ImmSrc} !== {(k == 0), 1'b1, 5'b00001, 3'b010}) begin
                        errors++;
                        $display("FAIL br%0d_branch: got %b expected %b", k,
                                 {PCWrite, retire, ALUControl, ImmSrc},
                                 {(k == 0), 1'b1, 5'b00001, 3'b010});
                    end
                end
                @(posedge clk); #1;
            end
            exp_instret++;
            mem_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (state !== 4'd0 || instret !== exp_instret) begin
                errors++;
                $display("FAIL br%0d_done: got state=%0d instret=%h expected 0/%h", k, state, instret, exp_instret);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_trap;
        set_instr(32'h0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'($urandom_range(0, 1)); Zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({state, illegal, PCWrite, IRWrite, RegWrite, MemWrite, MemRead, retire} !== {4'd15, 1'b1, 6'b0}) begin
                errors++;
                $display("FAIL trap_hold%0d: got state=%0d illegal=%b en=%b expected 15/1/000000", i, state,
                         illegal, {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, retire});
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        exp_instret = 32'd0;
        @(negedge clk);
        checks++;
        if ({state, illegal, instret} !== {4'd0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL trap_reset: got state=%0d illegal=%b instret=%h expected 0/0/0", state, illegal, instret);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_memwrite;
        set_instr({7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011});
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({state, ImmSrc} !== {4'd2, 3'b001}) begin
            errors++;
            $display("FAIL sw_memadr: got state=%0d ImmSrc=%b expected 2/001", state, ImmSrc);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({state, MemWrite, AdrSrc, retire} !== {4'd5, 3'b110}) begin
            errors++;
            $display("FAIL sw_memwrite: got state=%0d MW=%b Adr=%b ret=%b expected 5/1/1/0",
                     state, MemWrite, AdrSrc, retire);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({state, MemWrite, retire} !== {4'd5, 2'b00}) begin
            errors++;
            $display("FAIL sw_reset_cycle: got state=%0d MW=%b ret=%b expected 5/0/0", state, MemWrite, retire);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_instret = 32'd0;
        @(negedge clk);
        checks++;
        if ({state, instret} !== {4'd0, 32'd0}) begin
            errors++;
            $display("FAIL sw_after_reset: got state=%0d instret=%h expected 0/0", state, instret);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        mem_ready = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        set_instr(32'h002081B3);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (instret !== exp_instret) begin
                errors++;
                $display("FAIL wrap_pre%0d: got %h expected %h", i, instret, exp_instret);
            end
            @(posedge clk); #1;
        end
        exp_instret++;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (instret !== 32'h0000_0000 || instret !== exp_instret) begin
            errors++;
            $display("FAIL wrap_result: got %h expected 00000000", instret);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int          st_q[$];
        bit          mr_q[$];
        int          cls, fs, ms, code, s;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        bit          mr, z, pcw, ret, br_ok;
        logic [10:0] got, exp;
        for (int it = 0; it < 60; it++) begin
            cls = $urandom_range(0, 8);
            f3  = 3'($urandom_range(0, 7));
            f7  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                              : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
            fs  = $urandom_range(0, 2);
            ms  = $urandom_range(0, 3);
            case (cls)
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2: op = 7'b0110011;
                3: op = 7'b0010011;
                4: op = 7'b1100011;
                5: op = 7'b1101111;
                6: op = 7'b1100111;
                7: op = 7'b0110111;
                default: begin
                    op = 7'($urandom_range(0, 127));
                    for (int t = 0; t < 20 && is_known(op); t++) op = 7'($urandom_range(0, 127));
                    if (is_known(op)) op = 7'h00;
                end
            endcase
            if (cls == 4 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
            opcode = op; funct3 = f3; funct7 = f7;
            code  = alu_code(cls == 3, f7, f3);
            br_ok = (f3 == 3'd0) || (f3 == 3'd1);

            st_q.delete(); mr_q.delete();
            for (int i = 0; i <= fs; i++) begin st_q.push_back(0); mr_q.push_back(i == fs); end
            st_q.push_back(1); mr_q.push_back(1'b0);
            case (cls)
                0: begin
                    st_q.push_back(2); mr_q.push_back(1'b0);
                    for (int i = 0; i <= ms; i++) begin st_q.push_back(3); mr_q.push_back(i == ms); end
                    st_q.push_back(4); mr_q.push_back(1'b0);
                end
                1: begin
                    st_q.push_back(2); mr_q.push_back(1'b0);
                    for (int i = 0; i <= ms; i++) begin st_q.push_back(5); mr_q.push_back(i == ms); end
                end
                2, 3: begin
                    st_q.push_back(cls == 2 ? 6 : 7); st_q.push_back(code >= 0 ? 8 : 15);
                    mr_q.push_back(1'b0); mr_q.push_back(1'b0);
                end
                4: begin
                    st_q.push_back(9); mr_q.push_back(1'b0);
                    if (!br_ok) begin st_q.push_back(15); mr_q.push_back(1'b0); end
                end
                5: begin st_q.push_back(10); st_q.push_back(8); mr_q.push_back(1'b0); mr_q.push_back(1'b0); end
                6: begin
                    st_q.push_back(11); st_q.push_back(10); st_q.push_back(8);
                    mr_q.push_back(1'b0); mr_q.push_back(1'b0); mr_q.push_back(1'b0);
                end
                7: begin st_q.push_back(12); st_q.push_back(8); mr_q.push_back(1'b0); mr_q.push_back(1'b0); end
                default: begin st_q.push_back(15); mr_q.push_back(1'b0); end
            endcase

            for (int i = 0; i < st_q.size(); i++) begin
                s  = st_q[i];
                mr = (s == 0 || s == 3 || s == 5) ? mr_q[i] : 1'($urandom_range(0, 1));
                z  = 1'($urandom_range(0, 1));
                mem_ready = mr; Zero = z;
                pcw = (s == 0 && mr) || s == 10 || s == 11 ||
                      (s == 9 && ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z)));
                ret = s == 4 || s == 8 || (s == 5 && mr) || (s == 9 && br_ok);
                exp = {4'(s), pcw, (s == 0 && mr), (s == 4 || s == 8), (s == 5),
                       (s == 0 || s == 3), ret, (s == 15)};
                @(negedge clk);
                got = {state, PCWrite, IRWrite, RegWrite, MemWrite, MemRead, retire, illegal};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rnd%0d_cyc%0d op=%b f3=%0d: got %b expected %b", it, i, op, f3, got, exp);
                end
                checks++;
                if (instret !== exp_instret) begin
                    errors++;
                    $display("FAIL rnd%0d_instret: got %h expected %h", it, instret, exp_instret);
                end
                if ((s == 6 || s == 7) && code >= 0) begin
                    checks++;
                    if (ALUControl !== 5'(code)) begin
                        errors++;
                        $display("FAIL rnd%0d_aluctl: got %b expected %b", it, ALUControl, 5'(code));
                    end
                end
                if (ret) exp_instret++;
                @(posedge clk); #1;
            end
            if (st_q[st_q.size() - 1] == 15) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                exp_instret = 32'd0;
            end
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || instret !== exp_instret) begin
            errors++;
            $display("FAIL rnd_end: got state=%0d instret=%h expected 0/%h", state, instret, exp_instret);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        exp_instret = 32'd0;
        test_reset();
        test_add();
        test_lw_stall();
        test_branch();
        test_trap();
        test_reset_memwrite();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
